// File: rtl/acc_sum_accumulator.sv
// acc_sum_accumulator: sums ACC_LEN adder results per frame and hands the total downstream.
// Build macro ACC_OVF_EN adds a sticky carry-out flag on port ovf.
module acc_sum_accumulator #(
    parameter int WIDTH1  = 8,
    parameter int WIDTH2  = 8,
    parameter int ACC_LEN = 4,
    parameter int ACC_W   = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH1+WIDTH2-1:0] sum_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         acc_out
`ifdef ACC_OVF_EN
    ,
    output logic                     ovf
`endif
);

    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] next_acc;
    logic [CNT_W-1:0] count;
    logic             last;

    assign sum_ext  = ACC_W'(sum_in);
    assign in_ready = (state != HOLD);
    // With ACC_LEN == 1 the count never leaves zero, so every accept completes a frame.
    assign last     = (count == LAST);

`ifdef ACC_OVF_EN
    logic carry;
    logic ovf_sticky;
    assign {carry, next_acc} = {1'b0, acc} + {1'b0, sum_ext};
`else
    assign next_acc = acc + sum_ext;
`endif

    // Frame sequencer: clr outranks everything but rst and drops any same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            count      <= '0;
            acc_out    <= '0;
            out_valid  <= 1'b0;
`ifdef ACC_OVF_EN
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
`endif
        end else if (clr) begin
            state      <= IDLE;
            acc        <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
`ifdef ACC_OVF_EN
            ovf_sticky <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        if (last) begin
                            acc_out    <= next_acc;
                            out_valid  <= 1'b1;
                            acc        <= '0;
                            count      <= '0;
                            state      <= HOLD;
`ifdef ACC_OVF_EN
                            ovf        <= ovf_sticky | carry;
                            ovf_sticky <= 1'b0;
`endif
                        end else begin
                            acc        <= next_acc;
                            count      <= count + CNT_W'(1);
                            state      <= ACCUM;
`ifdef ACC_OVF_EN
                            ovf_sticky <= ovf_sticky | carry;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_sum_accumulator.sv
// Directed bench for acc_sum_accumulator: default build, a 16-bit accumulator
// instance for wrap-around, and an ACC_LEN=1 instance, all sharing one input set.
module tb_acc_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] sum_in = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [17:0] acc_out;
    logic        in_ready16, out_valid16;
    logic [15:0] acc_out16;
    logic        in_ready1, out_valid1;
    logic [17:0] acc_out1;
`ifdef ACC_OVF_EN
    logic        ovf, ovf16, ovf1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        in_valid;
        logic [15:0] sum;
        logic        out_ready;
        logic        exp_valid;
        logic        exp_ready;
        logic [17:0] exp_acc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    acc_sum_accumulator dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .sum_in(sum_in),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out)
`ifdef ACC_OVF_EN
        , .ovf(ovf)
`endif
    );

    acc_sum_accumulator #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready16), .sum_in(sum_in),
        .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc_out16)
`ifdef ACC_OVF_EN
        , .ovf(ovf16)
`endif
    );

    acc_sum_accumulator #(.ACC_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready1), .sum_in(sum_in),
        .out_valid(out_valid1), .out_ready(out_ready), .acc_out(acc_out1)
`ifdef ACC_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then land 1ns past the edge so outputs are settled.
    task automatic applyStimulus(input logic v, input logic [15:0] s, input logic ordy);
        in_valid  = v;
        sum_in    = s;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        in_valid  = 1'b0;
        sum_in    = '0;
        out_ready = 1'b0;
        clr       = 1'b0;
        rst       = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic v, input logic [15:0] s, input logic ordy,
                          input logic ev, input logic er, input logic [17:0] ea);
        vec_t t;
        t.in_valid  = v;
        t.sum       = s;
        t.out_ready = ordy;
        t.exp_valid = ev;
        t.exp_ready = er;
        t.exp_acc   = ea;
        vecs.push_back(t);
    endtask

    initial begin
        // Basic frame 100..400 with immediate acceptance downstream
        addVec(1, 100, 1, 0, 1, 0);
        addVec(1, 200, 1, 0, 1, 0);
        addVec(1, 300, 1, 0, 1, 0);
        addVec(1, 400, 1, 1, 0, 1000);
        addVec(0, 0,   1, 0, 1, 1000);
        addVec(0, 0,   1, 0, 1, 1000);
        // Gapped frame 10..40, then backpressure while inputs keep offering 999
        addVec(1, 10,  0, 0, 1, 1000);
        addVec(0, 0,   0, 0, 1, 1000);
        addVec(1, 20,  0, 0, 1, 1000);
        addVec(0, 0,   0, 0, 1, 1000);
        addVec(1, 30,  0, 0, 1, 1000);
        addVec(0, 0,   0, 0, 1, 1000);
        addVec(1, 40,  0, 1, 0, 100);
        for (int i = 0; i < 5; i++) addVec(1, 999, 0, 1, 0, 100);
        addVec(0, 0,   1, 0, 1, 100);
        addVec(1, 1,   1, 0, 1, 100);
        addVec(1, 1,   1, 0, 1, 100);
        addVec(1, 1,   1, 0, 1, 100);
        addVec(1, 1,   1, 1, 0, 4);
        addVec(0, 0,   1, 0, 1, 4);

        doReset();
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_acc_out", acc_out, 0);
        checkOutput("reset_out_valid16", out_valid16, 0);
        checkOutput("reset_out_valid1", out_valid1, 0);
`ifdef ACC_OVF_EN
        checkOutput("reset_ovf", ovf, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].in_valid, vecs[i].sum, vecs[i].out_ready);
            checkOutput($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ready);
            checkOutput($sformatf("vec%0d_acc_out", i), acc_out, vecs[i].exp_acc);
        end

        // Wrap-around on a 16-bit accumulator
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'hFFFF, 1);
        checkOutput("wrap16_out_valid", out_valid16, 1);
        checkOutput("wrap16_acc_out", acc_out16, 65532);
        checkOutput("wide18_acc_out", acc_out, 262140);
`ifdef ACC_OVF_EN
        checkOutput("wrap16_ovf", ovf16, 1);
        checkOutput("wide18_ovf", ovf, 0);
`endif
        applyStimulus(0, 0, 1);
        for (int i = 1; i <= 4; i++) applyStimulus(1, 16'(i), 1);
        checkOutput("after_wrap_out_valid", out_valid16, 1);
        checkOutput("after_wrap_acc_out", acc_out16, 10);
`ifdef ACC_OVF_EN
        checkOutput("after_wrap_ovf", ovf16, 0);
`endif
        applyStimulus(0, 0, 1);

        // clr mid-frame with a concurrent offer that must be dropped
        doReset();
        applyStimulus(1, 500, 1);
        applyStimulus(1, 600, 1);
        clr = 1'b1;
        applyStimulus(1, 700, 1);
        clr = 1'b0;
        checkOutput("clr_out_valid", out_valid, 0);
        checkOutput("clr_in_ready", in_ready, 1);
        for (int i = 1; i <= 4; i++) applyStimulus(1, 16'(i), 1);
        checkOutput("post_clr_out_valid", out_valid, 1);
        checkOutput("post_clr_acc_out", acc_out, 10);
        applyStimulus(0, 0, 1);

        // Asynchronous reset between edges after a prior total and three samples
        doReset();
        for (int i = 1; i <= 4; i++) applyStimulus(1, 16'(i), 0);
        checkOutput("pre_rst_acc_out", acc_out, 10);
        applyStimulus(0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_acc_out", acc_out, 0);
        checkOutput("async_rst_out_valid", out_valid, 0);
        checkOutput("async_rst_in_ready", in_ready, 1);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1, 5, 1);
        checkOutput("post_rst_out_valid", out_valid, 1);
        checkOutput("post_rst_acc_out", acc_out, 20);
        applyStimulus(0, 0, 1);

        // Single-sample frames
        doReset();
        applyStimulus(1, 7, 1);
        checkOutput("len1_a_out_valid", out_valid1, 1);
        checkOutput("len1_a_acc_out", acc_out1, 7);
        checkOutput("len1_a_in_ready", in_ready1, 0);
        applyStimulus(0, 0, 1);
        checkOutput("len1_a_done", out_valid1, 0);
        applyStimulus(1, 9, 1);
        checkOutput("len1_b_out_valid", out_valid1, 1);
        checkOutput("len1_b_acc_out", acc_out1, 9);
        checkOutput("len1_b_in_ready", in_ready1, 0);
        applyStimulus(0, 0, 1);
        checkOutput("len1_b_done", out_valid1, 0);
        checkOutput("len1_b_retained", acc_out1, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
